// File: rtl/ssa_spikes_streamer_pkg.sv
// Shared widths, line count and phase encoding for the SSA spike-line streamer.
// The widths follow the attention hyper-parameters (128 = 2 * systolic units * time steps).
package ssa_spikes_streamer_pkg;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 10;
  localparam int LINES  = 768;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINES - 1);

  typedef enum logic [2:0] {
    IDLE,
    KV_RD,
    KV_DRAIN,
    WAIT_KTV,
    Q_RD,
    Q_DRAIN
  } state_t;

endpackage

// File: rtl/ssa_spikes_streamer_if.sv
// Streamer-facing bundle: BRAM read ports, K/V and Q beat handshakes, pass control.
// The master side is the streamer; the slave side is the BRAM group plus compute array.
import ssa_spikes_streamer_pkg::*;

interface ssa_spikes_streamer_if;

  logic              i_SpikesTmpRam_Ready;
  logic              i_start;
  logic [ADDR_W-1:0] o_QueryRam_rdaddr;
  logic [DATA_W-1:0] i_QueryRam_out;
  logic [ADDR_W-1:0] o_KeyRam_rdaddr;
  logic [DATA_W-1:0] i_KeyRam_out;
  logic [ADDR_W-1:0] o_ValueRam_rdaddr;
  logic [DATA_W-1:0] i_ValueRam_out;
  logic              o_kv_valid;
  logic              i_kv_ready;
  logic [DATA_W-1:0] o_k_line;
  logic [DATA_W-1:0] o_v_line;
  logic              o_kv_last;
  logic              i_ktv_done;
  logic              o_q_valid;
  logic              i_q_ready;
  logic [DATA_W-1:0] o_q_line;
  logic              o_q_last;
  logic              o_busy;
  logic              o_done;

  modport master (
    input  i_SpikesTmpRam_Ready, i_start, i_QueryRam_out, i_KeyRam_out, i_ValueRam_out,
    input  i_kv_ready, i_ktv_done, i_q_ready,
    output o_QueryRam_rdaddr, o_KeyRam_rdaddr, o_ValueRam_rdaddr,
    output o_kv_valid, o_k_line, o_v_line, o_kv_last,
    output o_q_valid, o_q_line, o_q_last, o_busy, o_done
  );

  modport slave (
    output i_SpikesTmpRam_Ready, i_start, i_QueryRam_out, i_KeyRam_out, i_ValueRam_out,
    output i_kv_ready, i_ktv_done, i_q_ready,
    input  o_QueryRam_rdaddr, o_KeyRam_rdaddr, o_ValueRam_rdaddr,
    input  o_kv_valid, o_k_line, o_v_line, o_kv_last,
    input  o_q_valid, o_q_line, o_q_last, o_busy, o_done
  );

endinterface

// File: rtl/ssa_rd_skid_fifo.sv
// Small skid FIFO that catches BRAM read returns and carries a per-entry last flag.
// The head reads as zero while empty so downstream never sees stale lines.
module ssa_rd_skid_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic                       s_clk,
  input  logic                       s_rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       push_last,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic                       head_last,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             not_empty;

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head      = not_empty ? mem[rd_ptr][DATA_W-1:0] : '0;
  assign head_last = not_empty ? mem[rd_ptr][DATA_W] : 1'b0;

  always_ff @(posedge s_clk) begin
    if (do_push) mem[wr_ptr] <= {push_last, push_data};
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ssa_spikes_streamer.sv
// Streams paired K/V lines, then Q lines once K^T*V is ready, from the spike-line BRAMs.
// Reads are credit-limited so in-flight returns always fit in the per-stream skid FIFO.
import ssa_spikes_streamer_pkg::*;

module ssa_spikes_streamer #(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   s_clk,
  input logic                   s_rst,
  ssa_spikes_streamer_if.master bus
);

  // Address register adds one stage on top of the BRAM latency.
  localparam int PIPE_N = RD_LAT + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   issue_cnt;
  logic [PIPE_N-1:0]   pipe_vld;
  logic [PIPE_N-1:0]   pipe_last;
  logic [PIPE_N-1:0]   pipe_q;
  logic                ktv_seen;
  logic                kv_issue;
  logic                q_issue;
  logic                issue_last;
  logic                kv_room;
  logic                q_room;
  logic                kv_push;
  logic                q_push;
  logic                kv_pop;
  logic                q_pop;
  logic                phase_entry;
  logic [CNT_W-1:0]    kv_count;
  logic [CNT_W-1:0]    q_count;
  logic [2*DATA_W-1:0] kv_head;
  logic                kv_head_last;
  logic                q_head_last;
  int                  in_flight;

  always_comb begin
    in_flight = 0;
    for (int i = 0; i < PIPE_N; i++) begin
      if (pipe_vld[i]) in_flight = in_flight + 1;
    end
  end

  assign kv_room     = (in_flight + int'(kv_count)) < FIFO_DEPTH;
  assign q_room      = (in_flight + int'(q_count)) < FIFO_DEPTH;
  assign issue_last  = (issue_cnt == LAST_ADDR);
  assign kv_pop      = bus.o_kv_valid && bus.i_kv_ready;
  assign q_pop       = bus.o_q_valid && bus.i_q_ready;
  assign phase_entry = ((state == IDLE) && (state_next == KV_RD)) ||
                       ((state == WAIT_KTV) && (state_next == Q_RD));

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (bus.i_start && bus.i_SpikesTmpRam_Ready) state_next = KV_RD;
      KV_RD:    if (kv_issue && issue_last) state_next = KV_DRAIN;
      KV_DRAIN: if (kv_pop && kv_head_last) state_next = WAIT_KTV;
      WAIT_KTV: if (ktv_seen || bus.i_ktv_done) state_next = Q_RD;
      Q_RD:     if (q_issue && issue_last) state_next = Q_DRAIN;
      Q_DRAIN:  if (q_pop && q_head_last) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    kv_issue   = 1'b0;
    q_issue    = 1'b0;
    bus.o_busy = (state != IDLE);
    bus.o_done = 1'b0;
    case (state)
      KV_RD:   kv_issue   = kv_room;
      Q_RD:    q_issue    = q_room;
      Q_DRAIN: bus.o_done = q_pop && q_head_last;
      default: ;
    endcase
  end

  // An early K^T*V completion is remembered until the Q phase actually begins.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      ktv_seen <= 1'b0;
    end else begin
      ktv_seen <= ((state == KV_RD) || (state == KV_DRAIN) || (state == WAIT_KTV)) &&
                  (state_next != Q_RD) && (ktv_seen || bus.i_ktv_done);
    end
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      issue_cnt             <= '0;
      bus.o_KeyRam_rdaddr   <= '0;
      bus.o_ValueRam_rdaddr <= '0;
      bus.o_QueryRam_rdaddr <= '0;
    end else begin
      if (phase_entry)                            issue_cnt <= '0;
      else if ((kv_issue || q_issue) && !issue_last) issue_cnt <= issue_cnt + ADDR_W'(1);
      if (kv_issue) begin
        bus.o_KeyRam_rdaddr   <= issue_cnt;
        bus.o_ValueRam_rdaddr <= issue_cnt;
      end
      if (q_issue) bus.o_QueryRam_rdaddr <= issue_cnt;
    end
  end

  // Clearing this pipeline on reset is what discards returns still inside the BRAM.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
      pipe_q    <= '0;
    end else begin
      pipe_vld  <= {pipe_vld[PIPE_N-2:0], kv_issue || q_issue};
      pipe_last <= {pipe_last[PIPE_N-2:0], (kv_issue || q_issue) && issue_last};
      pipe_q    <= {pipe_q[PIPE_N-2:0], q_issue};
    end
  end

  assign kv_push = pipe_vld[PIPE_N-1] && !pipe_q[PIPE_N-1];
  assign q_push  = pipe_vld[PIPE_N-1] && pipe_q[PIPE_N-1];

  ssa_rd_skid_fifo #(
    .DATA_W (2 * DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) kv_fifo (
    .s_clk     (s_clk),
    .s_rst     (s_rst),
    .push      (kv_push),
    .push_data ({bus.i_KeyRam_out, bus.i_ValueRam_out}),
    .push_last (pipe_last[PIPE_N-1]),
    .pop       (kv_pop),
    .head      (kv_head),
    .head_last (kv_head_last),
    .count     (kv_count)
  );

  ssa_rd_skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) q_fifo (
    .s_clk     (s_clk),
    .s_rst     (s_rst),
    .push      (q_push),
    .push_data (bus.i_QueryRam_out),
    .push_last (pipe_last[PIPE_N-1]),
    .pop       (q_pop),
    .head      (bus.o_q_line),
    .head_last (q_head_last),
    .count     (q_count)
  );

  assign bus.o_kv_valid = (kv_count != '0);
  assign bus.o_k_line   = kv_head[2*DATA_W-1:DATA_W];
  assign bus.o_v_line   = kv_head[DATA_W-1:0];
  assign bus.o_kv_last  = kv_head_last;
  assign bus.o_q_valid  = (q_count != '0);
  assign bus.o_q_last   = q_head_last;

endmodule

// File: tb/tb_ssa_spikes_streamer.sv
// Directed bench: BRAM model with tagged lines, full K/V and Q passes, backpressure,
// latched K^T*V completion and a mid-pass reset.
import ssa_spikes_streamer_pkg::*;

module tb_ssa_spikes_streamer;

  logic s_clk = 1'b0;
  logic s_rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  int                n;
  int                first;
  int                outstanding;
  logic              r;
  logic              kt;
  logic              ktv_sent;
  logic              stall_prev;
  logic              reset_hit;
  logic [DATA_W-1:0] prev_k;
  logic [DATA_W-1:0] prev_v;
  logic              prev_last;

  ssa_spikes_streamer_if bus ();

  ssa_spikes_streamer #(
    .RD_LAT     (1),
    .FIFO_DEPTH (4)
  ) dut (
    .s_clk (s_clk),
    .s_rst (s_rst),
    .bus   (bus)
  );

  always #5 s_clk = ~s_clk;

  // Line n of each matrix carries a matrix tag and its own index; out-of-range reads give 0.
  function automatic logic [DATA_W-1:0] lineOf(input logic [3:0] tag, input logic [ADDR_W-1:0] a);
    lineOf = '0;
    if (int'(a) < LINES) lineOf = {8{tag, 2'b00, a}};
  endfunction

  always @(posedge s_clk) begin
    bus.i_KeyRam_out   <= lineOf(4'hA, bus.o_KeyRam_rdaddr);
    bus.i_ValueRam_out <= lineOf(4'hB, bus.o_ValueRam_rdaddr);
    bus.i_QueryRam_out <= lineOf(4'hC, bus.o_QueryRam_rdaddr);
  end

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle's inputs just after the edge, then leaves time for outputs to settle.
  task automatic applyStimulus(input logic start, input logic ktv, input logic kvr, input logic qr);
    @(posedge s_clk);
    #1;
    bus.i_start    = start;
    bus.i_ktv_done = ktv;
    bus.i_kv_ready = kvr;
    bus.i_q_ready  = qr;
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, DATA_W'(bus.o_busy), '0);
    checkOutput({tag, "_done"}, DATA_W'(bus.o_done), '0);
    checkOutput({tag, "_kv_valid"}, DATA_W'(bus.o_kv_valid), '0);
    checkOutput({tag, "_q_valid"}, DATA_W'(bus.o_q_valid), '0);
    checkOutput({tag, "_k_line"}, bus.o_k_line, '0);
    checkOutput({tag, "_q_line"}, bus.o_q_line, '0);
    checkOutput({tag, "_kv_last"}, DATA_W'(bus.o_kv_last), '0);
    checkOutput({tag, "_q_last"}, DATA_W'(bus.o_q_last), '0);
    checkOutput({tag, "_k_addr"}, DATA_W'(bus.o_KeyRam_rdaddr), '0);
    checkOutput({tag, "_v_addr"}, DATA_W'(bus.o_ValueRam_rdaddr), '0);
    checkOutput({tag, "_q_addr"}, DATA_W'(bus.o_QueryRam_rdaddr), '0);
  endtask

  initial begin
    bus.i_SpikesTmpRam_Ready = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_ktv_done = 1'b0;
    bus.i_kv_ready = 1'b0;
    bus.i_q_ready  = 1'b0;

    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkAllZero("reset");
    s_rst = 1'b0;

    $display("[TB] start with Ready=0 and K^T*V done in IDLE are ignored");
    applyStimulus(1, 1, 0, 0);
    for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 0);
    checkAllZero("not_ready");

    $display("[TB] pass 1: K/V phase with ready held high");
    bus.i_SpikesTmpRam_Ready = 1'b1;
    applyStimulus(1, 0, 1, 1);
    n = 0;
    first = -1;
    for (int c = 0; c < 2000 && n < LINES; c++) begin
      applyStimulus(0, 0, 1, 1);
      if (c == 0) checkOutput("busy_after_start", DATA_W'(bus.o_busy), DATA_W'(1));
      if (c == 1) checkOutput("k_addr_first", DATA_W'(bus.o_KeyRam_rdaddr), '0);
      if (bus.o_kv_valid) begin
        if (first < 0) begin
          first = c;
          checkOutput("kv_first_latency", DATA_W'(c), DATA_W'(3));
        end
        checkOutput("kv_gapless", DATA_W'(c), DATA_W'(first + n));
        checkOutput("k_line", bus.o_k_line, lineOf(4'hA, ADDR_W'(n)));
        checkOutput("v_line", bus.o_v_line, lineOf(4'hB, ADDR_W'(n)));
        checkOutput("kv_last", DATA_W'(bus.o_kv_last), DATA_W'(n == LINES - 1));
        n++;
      end
    end
    checkOutput("kv_beat_count", DATA_W'(n), DATA_W'(LINES));

    for (int c = 0; c < 6; c++) begin
      applyStimulus(0, 0, 1, 1);
      checkOutput("wait_ktv_busy", DATA_W'(bus.o_busy), DATA_W'(1));
      checkOutput("wait_ktv_no_q", DATA_W'(bus.o_q_valid), '0);
      checkOutput("wait_ktv_q_addr", DATA_W'(bus.o_QueryRam_rdaddr), '0);
    end

    $display("[TB] pass 1: Q phase after K^T*V done");
    applyStimulus(0, 1, 1, 1);
    n = 0;
    first = -1;
    for (int c = 0; c < 2000 && n < LINES; c++) begin
      applyStimulus(0, 0, 1, 1);
      if (bus.o_q_valid) begin
        if (first < 0) begin
          first = c;
          checkOutput("q_first_latency", DATA_W'(c), DATA_W'(3));
        end
        checkOutput("q_gapless", DATA_W'(c), DATA_W'(first + n));
        checkOutput("q_line", bus.o_q_line, lineOf(4'hC, ADDR_W'(n)));
        checkOutput("q_last", DATA_W'(bus.o_q_last), DATA_W'(n == LINES - 1));
        checkOutput("q_done", DATA_W'(bus.o_done), DATA_W'(n == LINES - 1));
        n++;
      end else begin
        checkOutput("q_done_quiet", DATA_W'(bus.o_done), '0);
      end
    end
    checkOutput("q_beat_count", DATA_W'(n), DATA_W'(LINES));
    applyStimulus(0, 0, 1, 1);
    checkOutput("idle_busy", DATA_W'(bus.o_busy), '0);
    checkOutput("idle_done", DATA_W'(bus.o_done), '0);
    checkOutput("idle_q_valid", DATA_W'(bus.o_q_valid), '0);
    checkOutput("q_addr_held", DATA_W'(bus.o_QueryRam_rdaddr), DATA_W'(LINES - 1));

    $display("[TB] pass 2: random K/V backpressure, K^T*V done during drain");
    applyStimulus(1, 0, 0, 0);
    n = 0;
    ktv_sent = 1'b0;
    stall_prev = 1'b0;
    for (int c = 0; c < 5000 && n < LINES; c++) begin
      r  = 1'($urandom_range(0, 1));
      kt = !ktv_sent && (n > 0) && (bus.o_KeyRam_rdaddr == LAST_ADDR);
      if (kt) ktv_sent = 1'b1;
      applyStimulus(0, kt, r, 0);
      if (stall_prev) begin
        checkOutput("bp_hold_valid", DATA_W'(bus.o_kv_valid), DATA_W'(1));
        checkOutput("bp_hold_k", bus.o_k_line, prev_k);
        checkOutput("bp_hold_v", bus.o_v_line, prev_v);
        checkOutput("bp_hold_last", DATA_W'(bus.o_kv_last), DATA_W'(prev_last));
      end
      if (c >= 1) begin
        outstanding = int'(bus.o_KeyRam_rdaddr) + 1 - n;
        checkOutput("bp_outstanding_le4", DATA_W'(outstanding <= 4), DATA_W'(1));
      end
      if (bus.o_kv_valid && r) begin
        checkOutput("bp_k_line", bus.o_k_line, lineOf(4'hA, ADDR_W'(n)));
        checkOutput("bp_v_line", bus.o_v_line, lineOf(4'hB, ADDR_W'(n)));
        checkOutput("bp_kv_last", DATA_W'(bus.o_kv_last), DATA_W'(n == LINES - 1));
        n++;
      end
      stall_prev = bus.o_kv_valid && !r;
      prev_k     = bus.o_k_line;
      prev_v     = bus.o_v_line;
      prev_last  = bus.o_kv_last;
    end
    checkOutput("bp_beat_count", DATA_W'(n), DATA_W'(LINES));
    checkOutput("bp_ktv_sent", DATA_W'(ktv_sent), DATA_W'(1));

    applyStimulus(0, 0, 0, 1);
    checkOutput("latched_wait_busy", DATA_W'(bus.o_busy), DATA_W'(1));
    checkOutput("latched_wait_no_q", DATA_W'(bus.o_q_valid), '0);

    $display("[TB] pass 2: Q phase, reset at beat 300");
    n = 0;
    first = -1;
    reset_hit = 1'b0;
    for (int c = 0; c < 1000 && !reset_hit; c++) begin
      applyStimulus(0, 0, 0, 1);
      if (c == 0) checkOutput("q_addr_before_issue", DATA_W'(bus.o_QueryRam_rdaddr), DATA_W'(LINES - 1));
      if (c == 1) checkOutput("q_addr_restart", DATA_W'(bus.o_QueryRam_rdaddr), '0);
      if (bus.o_q_valid) begin
        if (first < 0) begin
          first = c;
          checkOutput("q_latched_latency", DATA_W'(c), DATA_W'(3));
        end
        checkOutput("q2_line", bus.o_q_line, lineOf(4'hC, ADDR_W'(n)));
        if (n == 300) begin
          #1 s_rst = 1'b1;
          #1;
          reset_hit = 1'b1;
          checkAllZero("async_reset");
        end
        n++;
      end
    end
    checkOutput("reset_reached", DATA_W'(reset_hit), DATA_W'(1));
    applyStimulus(0, 0, 0, 1);
    checkAllZero("reset_held");
    s_rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 0, 1, 1);
      checkOutput("post_reset_no_kv", DATA_W'(bus.o_kv_valid), '0);
      checkOutput("post_reset_no_q", DATA_W'(bus.o_q_valid), '0);
      checkOutput("post_reset_idle", DATA_W'(bus.o_busy), '0);
    end

    $display("[TB] pass 3: fresh start restarts at K/V index 0");
    applyStimulus(1, 0, 1, 0);
    n = 0;
    first = -1;
    for (int c = 0; c < 50 && n < 4; c++) begin
      applyStimulus(0, 0, 1, 0);
      if (bus.o_kv_valid) begin
        if (first < 0) begin
          first = c;
          checkOutput("restart_latency", DATA_W'(c), DATA_W'(3));
        end
        checkOutput("restart_k_line", bus.o_k_line, lineOf(4'hA, ADDR_W'(n)));
        checkOutput("restart_v_line", bus.o_v_line, lineOf(4'hB, ADDR_W'(n)));
        n++;
      end
    end
    checkOutput("restart_beats", DATA_W'(n), DATA_W'(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
